sr595_serializer: RTL and testbench
===================================

// Module: sr595_serializer
// PURPOSE
//   Serial link from the display datapath to a chain of 74HC595 shift registers.
//   The upstream segment/digit encoder offers one parallel word per refresh via valid/ready.
//   The block shifts the word out MSB-first on sclk_o/data_o, then pulses latch_o once to update the 595 outputs.
//   Its pins drive uo_out[2:0] of the clock top level.
// PARAMETERS
//   NUM_ICS       2   number of chained 595s; word width W = 8*NUM_ICS
//   CLK_DIV       4   clk cycles per sclk half-period (>=1)
//   LATCH_CYCLES  1   clk cycles latch_o is held high (>=1)
// PORTS
//   clk      in   1   system clock, all state on rising edge
//   rst_n    in   1   asynchronous, active-low reset
//   data_i   in   W   word to send; data_i[W-1] is shifted first (lands in last 595 of the chain)
//   valid_i  in   1   upstream has a word on data_i
//   ready_o  out  1   block can accept; transfer happens on a clk edge where valid_i && ready_o
//   sclk_o   out  1   595 SRCLK
//   data_o   out  1   595 SER
//   latch_o  out  1   595 RCLK
//   busy_o   out  1   transaction in progress (== !ready_o)
//   done_o   out  1   one-cycle pulse when a word has been latched
// BEHAVIOUR
//   Reset (async assert, sync release) forces:
//     state=IDLE, ready_o=1, busy_o=0, sclk_o=0, data_o=0, latch_o=0, done_o=0, counters=0.
//   FSM states: IDLE -> SHIFT_LO -> SHIFT_HI -> (SHIFT_LO | LATCH) -> IDLE.
//   IDLE
//     ready_o=1; on valid_i, capture data_i into shift reg at edge E0 and go to SHIFT_LO.
//     At E0: data_o <= data_i[W-1], sclk_o stays 0.
//   SHIFT_LO
//     Hold CLK_DIV cycles, then sclk_o<=1 and go to SHIFT_HI.
//     Bit k (k=0..W-1) rises at E0+(2k+1)*CLK_DIV.
//   SHIFT_HI
//     Hold CLK_DIV cycles, then sclk_o<=0.
//     If bit_cnt==W-1: go to LATCH, latch_o<=1.
//     Else: shift reg left 1, data_o <= next bit, bit_cnt++, go to SHIFT_LO.
//   data_o changes only on sclk_o falling edge (or at E0); it is stable >=CLK_DIV cycles around each rise.
//   LATCH
//     latch_o high from E0+2W*CLK_DIV for LATCH_CYCLES cycles.
//     At E0+2W*CLK_DIV+LATCH_CYCLES: latch_o<=0, done_o<=1 for 1 cycle, data_o<=0, go to IDLE (ready_o=1).
//   Latency: accept to latch rise = 2*W*CLK_DIV cycles; accept to done = 2*W*CLK_DIV+LATCH_CYCLES cycles.
//   Exactly W sclk rising edges and exactly one latch pulse per accepted word; latch_o never high while sclk_o high.
//   Back-to-back: valid_i held high is accepted the first edge ready_o is 1 (the done_o cycle); no gap cycle added.
//   data_i/valid_i are ignored while busy; no queuing, no word lost or duplicated once accepted.
//   Reset mid-transaction: abort immediately, outputs to reset values, no latch pulse (595 outputs keep the previous word).
//   Counters: div_cnt sized $clog2(max(CLK_DIV,LATCH_CYCLES))+1 bits; bit_cnt sized $clog2(W)+1 bits; no wrap inside a transaction.
// TESTING
//   1. NUM_ICS=2, CLK_DIV=2, LATCH_CYCLES=1, send 16'hA5C3.
//      -> data_o sampled at the 16 sclk rises = 1010_0101_1100_0011.
//      -> latch_o high exactly at E0+64; done_o at E0+65; 595 model outputs A5C3.
//   2. valid_i held high with words 16'h0001, 16'h8000.
//      -> second accept on the done_o cycle of the first; model shows 0001 then 8000.
//      -> 32 sclk rises total, 2 latch pulses.
//   3. Change data_i and pulse valid_i mid-shift of 16'hFFFF.
//      -> ignored; model latches FFFF; ready_o=0 throughout.
//   4. Assert rst_n=0 after 7 sclk rises of 16'h1234.
//      -> all outputs 0 asynchronously, ready_o=1, no latch pulse; model outputs unchanged.
//   5. NUM_ICS=1, CLK_DIV=1, LATCH_CYCLES=3, send 8'h81.
//      -> 8 rises; latch_o high for 3 cycles from E0+16; done_o at E0+19.
//   6. Random words and random valid gaps, 1000 transactions.
//      -> scoreboard match; assert latch_o and sclk_o never both high; assert busy_o == !ready_o.

Source files
------------

// File: rtl/sr595_serializer.sv
// sr595_serializer: shifts one parallel word MSB-first into a chain of 74HC595
// shift registers. A single latch pulse then updates the 595 outputs.
// Handshake is valid/ready. Words offered while a transfer is in flight are ignored.

module sr595_serializer #(
    parameter int NUM_ICS      = 2,
    parameter int CLK_DIV      = 4,
    parameter int LATCH_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [8*NUM_ICS-1:0]   data_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic                   sclk_o,
    output logic                   data_o,
    output logic                   latch_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int W       = 8 * NUM_ICS;
    localparam int MAX_DIV = (CLK_DIV > LATCH_CYCLES) ? CLK_DIV : LATCH_CYCLES;
    localparam int DIV_W   = $clog2(MAX_DIV) + 1;
    localparam int BIT_W   = $clog2(W) + 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] LATCH_LAST = DIV_W'(LATCH_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(W - 1);
    localparam logic [BIT_W-1:0] BIT_ONE    = BIT_W'(1);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StShiftLo = 2'd1;
    localparam logic [1:0] StShiftHi = 2'd2;
    localparam logic [1:0] StLatch   = 2'd3;

    logic [1:0]       state_q,   state_d;
    logic [W-1:0]     shift_q,   shift_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             sclk_q,    sclk_d;
    logic             data_q,    data_d;
    logic             latch_q,   latch_d;
    logic             done_q,    done_d;

    // Next-state logic: each phase holds for its divider count, then advances.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        sclk_d    = sclk_q;
        data_d    = data_q;
        latch_d   = latch_q;
        done_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (valid_i) begin
                    shift_d   = data_i;
                    data_d    = data_i[W-1];
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = StShiftLo;
                end
            end
            StShiftLo: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    sclk_d    = 1'b1;
                    state_d   = StShiftHi;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_ONE;
                end
            end
            StShiftHi: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    sclk_d    = 1'b0;
                    if (bit_cnt_q == BIT_LAST) begin
                        // Latch rises on the same edge sclk falls, so they never overlap.
                        latch_d = 1'b1;
                        state_d = StLatch;
                    end else begin
                        // Next bit changes only on the falling sclk edge.
                        shift_d   = shift_q << 1;
                        data_d    = shift_q[W-2];
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                        state_d   = StShiftLo;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_ONE;
                end
            end
            StLatch: begin
                if (div_cnt_q == LATCH_LAST) begin
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    latch_d   = 1'b0;
                    data_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = StIdle;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_ONE;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers. Reset aborts any transfer without a latch pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            sclk_q    <= 1'b0;
            data_q    <= 1'b0;
            latch_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            sclk_q    <= sclk_d;
            data_q    <= data_d;
            latch_q   <= latch_d;
            done_q    <= done_d;
        end
    end

    // Outputs. Ready is purely the idle state, so a word can be taken on the done cycle.
    always_comb begin
        ready_o = (state_q == StIdle);
        busy_o  = (state_q != StIdle);
        sclk_o  = sclk_q;
        data_o  = data_q;
        latch_o = latch_q;
        done_o  = done_q;
    end

endmodule

// File: tb/tb_sr595_serializer.sv
// Testbench for sr595_serializer. Two instances: A (2 ICs, div 2, latch 1) and B (1 IC, div 1,
// latch 3). A 595 chain model and a word scoreboard follow both instances every cycle.

module tb_sr595_serializer;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  valid_in = 2'b00;
    logic [15:0] data_in [2];
    logic [1:0]  ready_w, busy_w, sclk_w, sdo_w, latch_w, done_w;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    int w_p  [2] = '{16, 8};
    int cd_p [2] = '{2, 1};
    int lc_p [2] = '{1, 3};

    // Model state per instance.
    bit inflight [2];
    bit sclk_p   [2];
    bit latch_p  [2];
    int word     [2];
    int sr       [2];
    int out595   [2];
    int e0       [2];
    int rc       [2];
    int lat_hi   [2];
    int acc_cnt  [2];
    int rise_cnt [2];
    int latch_cnt[2];
    int done_cnt [2];
    int last_e0  [2];
    int last_latch_t [2];
    int last_done_t  [2];
    int last_lat_w   [2];

    always #5 clk = ~clk;

    sr595_serializer #(.NUM_ICS(2), .CLK_DIV(2), .LATCH_CYCLES(1)) dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (data_in[0]),
        .valid_i (valid_in[0]),
        .ready_o (ready_w[0]),
        .sclk_o  (sclk_w[0]),
        .data_o  (sdo_w[0]),
        .latch_o (latch_w[0]),
        .busy_o  (busy_w[0]),
        .done_o  (done_w[0])
    );

    sr595_serializer #(.NUM_ICS(1), .CLK_DIV(1), .LATCH_CYCLES(3)) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (data_in[1][7:0]),
        .valid_i (valid_in[1]),
        .ready_o (ready_w[1]),
        .sclk_o  (sclk_w[1]),
        .data_o  (sdo_w[1]),
        .latch_o (latch_w[1]),
        .busy_o  (busy_w[1]),
        .done_o  (done_w[1])
    );

    // Posedge counter: at a negedge, cyc is the index of the most recent rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc <= cyc + 1;
        end
    end

    // 595 chain model plus timing scoreboard, sampled on the falling clock edge.
    initial begin
        for (int d = 0; d < 2; d++) begin
            inflight[d] = 0; sclk_p[d] = 0; latch_p[d] = 0; sr[d] = 0; out595[d] = 0;
            rc[d] = 0; lat_hi[d] = 0; acc_cnt[d] = 0; rise_cnt[d] = 0; latch_cnt[d] = 0;
            done_cnt[d] = 0; e0[d] = 0; word[d] = 0; last_lat_w[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                int m;
                m = (1 << w_p[d]) - 1;
                vectors++;
                if (!rst_n) begin
                    if ({ready_w[d], busy_w[d], sclk_w[d], sdo_w[d], latch_w[d], done_w[d]}
                        !== 6'b100000) begin
                        miscompares++;
                        $display("FAIL reset_hold dut%0d: outputs %b, required 100000", d,
                                 {ready_w[d], busy_w[d], sclk_w[d], sdo_w[d], latch_w[d],
                                  done_w[d]});
                    end
                    inflight[d] = 0; lat_hi[d] = 0; sclk_p[d] = 0; latch_p[d] = 0;
                end else begin
                    if ((latch_w[d] && sclk_w[d]) || (busy_w[d] !== !ready_w[d])) begin
                        miscompares++;
                        $display("FAIL invariant dut%0d @%0d: latch=%b sclk=%b busy=%b ready=%b",
                                 d, cyc, latch_w[d], sclk_w[d], busy_w[d], ready_w[d]);
                    end
                    if (sclk_w[d] && !sclk_p[d]) begin
                        sr[d] = ((sr[d] << 1) | int'(sdo_w[d])) & m;
                        rise_cnt[d]++;
                        vectors++;
                        if (!inflight[d] || cyc != e0[d] + (2 * rc[d] + 1) * cd_p[d]) begin
                            miscompares++;
                            $display("FAIL sclk_rise dut%0d: rise at %0d, required %0d (bit %0d)",
                                     d, cyc, e0[d] + (2 * rc[d] + 1) * cd_p[d], rc[d]);
                        end
                        rc[d]++;
                    end
                    if (latch_w[d] && !latch_p[d]) begin
                        out595[d] = sr[d];
                        latch_cnt[d]++;
                        last_latch_t[d] = cyc;
                        vectors++;
                        if (!inflight[d] || rc[d] != w_p[d] ||
                            cyc != e0[d] + 2 * w_p[d] * cd_p[d] || out595[d] != word[d]) begin
                            miscompares++;
                            $display("FAIL latch dut%0d: t=%0d rises=%0d out=%h, required t=%0d rises=%0d out=%h",
                                     d, cyc, rc[d], out595[d], e0[d] + 2 * w_p[d] * cd_p[d],
                                     w_p[d], word[d]);
                        end
                    end
                    if (latch_w[d]) lat_hi[d]++;
                    if (done_w[d]) begin
                        done_cnt[d]++;
                        last_done_t[d] = cyc;
                        last_lat_w[d] = lat_hi[d];
                        vectors++;
                        if (!inflight[d] || cyc != e0[d] + 2 * w_p[d] * cd_p[d] + lc_p[d] ||
                            lat_hi[d] != lc_p[d]) begin
                            miscompares++;
                            $display("FAIL done dut%0d: t=%0d latch_w=%0d, required t=%0d latch_w=%0d",
                                     d, cyc, lat_hi[d], e0[d] + 2 * w_p[d] * cd_p[d] + lc_p[d],
                                     lc_p[d]);
                        end
                        inflight[d] = 0;
                        lat_hi[d] = 0;
                    end
                    vectors++;
                    if (ready_w[d] !== !inflight[d]) begin
                        miscompares++;
                        $display("FAIL ready_state dut%0d @%0d: ready=%b, required %b", d, cyc,
                                 ready_w[d], !inflight[d]);
                    end
                    if (valid_in[d] && ready_w[d]) begin
                        inflight[d] = 1;
                        word[d] = int'(data_in[d]) & m;
                        e0[d] = cyc + 1;
                        last_e0[d] = cyc + 1;
                        rc[d] = 0;
                        acc_cnt[d]++;
                    end
                    sclk_p[d] = sclk_w[d];
                    latch_p[d] = latch_w[d];
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if ({ready_w[d], busy_w[d], sclk_w[d], sdo_w[d], latch_w[d], done_w[d]} !== 6'b100000)
            begin
                miscompares++;
                $display("FAIL reset_state dut%0d: outputs %b, required 100000", d,
                         {ready_w[d], busy_w[d], sclk_w[d], sdo_w[d], latch_w[d], done_w[d]});
            end
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_pattern_a5c3();
        int a0, dn0, l0, r0, i;
        a0 = acc_cnt[0]; dn0 = done_cnt[0]; l0 = latch_cnt[0]; r0 = rise_cnt[0];
        @(posedge clk); #2;
        data_in[0] = 16'hA5C3; valid_in[0] = 1'b1;
        i = 0;
        while (acc_cnt[0] == a0 && i < 50) begin @(negedge clk); #1; i++; end
        @(posedge clk); #2;
        valid_in[0] = 1'b0;
        i = 0;
        while (done_cnt[0] == dn0 && i < 500) begin @(negedge clk); #1; i++; end
        vectors++;
        if (done_cnt[0] == dn0) begin
            miscompares++;
            $display("FAIL a5c3_timeout: done count %0d, required %0d", done_cnt[0], dn0 + 1);
        end
        vectors++;
        if (out595[0] != 32'hA5C3) begin
            miscompares++;
            $display("FAIL a5c3_out: model %h, required a5c3", out595[0]);
        end
        vectors++;
        if (rise_cnt[0] - r0 != 16 || latch_cnt[0] - l0 != 1) begin
            miscompares++;
            $display("FAIL a5c3_counts: rises %0d latches %0d, required 16 and 1",
                     rise_cnt[0] - r0, latch_cnt[0] - l0);
        end
        vectors++;
        if (last_latch_t[0] - last_e0[0] != 64 || last_done_t[0] - last_e0[0] != 65) begin
            miscompares++;
            $display("FAIL a5c3_latency: latch +%0d done +%0d, required +64 and +65",
                     last_latch_t[0] - last_e0[0], last_done_t[0] - last_e0[0]);
        end
    endtask

    task automatic test_back_to_back();
        int a0, dn0, l0, r0, i, first_done;
        a0 = acc_cnt[0]; dn0 = done_cnt[0]; l0 = latch_cnt[0]; r0 = rise_cnt[0];
        @(posedge clk); #2;
        data_in[0] = 16'h0001; valid_in[0] = 1'b1;
        i = 0;
        while (acc_cnt[0] == a0 && i < 50) begin @(negedge clk); #1; i++; end
        @(posedge clk); #2;
        data_in[0] = 16'h8000;
        i = 0;
        while (latch_cnt[0] == l0 && i < 500) begin @(negedge clk); #1; i++; end
        vectors++;
        if (out595[0] != 32'h0001) begin
            miscompares++;
            $display("FAIL b2b_first_out: model %h, required 0001", out595[0]);
        end
        i = 0;
        while (acc_cnt[0] < a0 + 2 && i < 100) begin @(negedge clk); #1; i++; end
        first_done = last_done_t[0];
        vectors++;
        if (acc_cnt[0] != a0 + 2 || last_e0[0] != first_done + 1) begin
            miscompares++;
            $display("FAIL b2b_accept: second accept at %0d, required %0d", last_e0[0],
                     first_done + 1);
        end
        @(posedge clk); #2;
        valid_in[0] = 1'b0;
        i = 0;
        while (done_cnt[0] < dn0 + 2 && i < 500) begin @(negedge clk); #1; i++; end
        vectors++;
        if (out595[0] != 32'h8000) begin
            miscompares++;
            $display("FAIL b2b_second_out: model %h, required 8000", out595[0]);
        end
        vectors++;
        if (rise_cnt[0] - r0 != 32 || latch_cnt[0] - l0 != 2) begin
            miscompares++;
            $display("FAIL b2b_counts: rises %0d latches %0d, required 32 and 2",
                     rise_cnt[0] - r0, latch_cnt[0] - l0);
        end
    endtask

    task automatic test_ignore_busy();
        int a0, dn0, l0, i;
        a0 = acc_cnt[0]; dn0 = done_cnt[0]; l0 = latch_cnt[0];
        @(posedge clk); #2;
        data_in[0] = 16'hFFFF; valid_in[0] = 1'b1;
        i = 0;
        while (acc_cnt[0] == a0 && i < 50) begin @(negedge clk); #1; i++; end
        for (int k = 0; k < 55; k++) begin
            @(posedge clk); #2;
            data_in[0] = 16'($urandom);
            valid_in[0] = 1'($urandom_range(0, 1));
            @(negedge clk); #1;
            vectors++;
            if (ready_w[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL ignore_ready cycle %0d: ready %b, required 0", k, ready_w[0]);
            end
        end
        valid_in[0] = 1'b0;
        i = 0;
        while (done_cnt[0] == dn0 && i < 100) begin @(negedge clk); #1; i++; end
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (out595[0] != 32'hFFFF || acc_cnt[0] != a0 + 1 || latch_cnt[0] != l0 + 1) begin
            miscompares++;
            $display("FAIL ignore_result: out %h accepts %0d latches %0d, required ffff 1 1",
                     out595[0], acc_cnt[0] - a0, latch_cnt[0] - l0);
        end
    endtask

    task automatic test_reset_abort();
        int a0, l0, dn0, r0, prev_out, i;
        a0 = acc_cnt[0]; l0 = latch_cnt[0]; dn0 = done_cnt[0]; r0 = rise_cnt[0];
        prev_out = out595[0];
        @(posedge clk); #2;
        data_in[0] = 16'h1234; valid_in[0] = 1'b1;
        i = 0;
        while (acc_cnt[0] == a0 && i < 50) begin @(negedge clk); #1; i++; end
        @(posedge clk); #2;
        valid_in[0] = 1'b0;
        i = 0;
        while (rise_cnt[0] < r0 + 7 && i < 200) begin @(negedge clk); #1; i++; end
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({ready_w[0], busy_w[0], sclk_w[0], sdo_w[0], latch_w[0], done_w[0]} !== 6'b100000)
        begin
            miscompares++;
            $display("FAIL abort_outputs: outputs %b, required 100000",
                     {ready_w[0], busy_w[0], sclk_w[0], sdo_w[0], latch_w[0], done_w[0]});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        #1;
        vectors++;
        if (latch_cnt[0] != l0 || done_cnt[0] != dn0 || out595[0] != prev_out) begin
            miscompares++;
            $display("FAIL abort_no_latch: latches %0d done %0d out %h, required 0 0 %h",
                     latch_cnt[0] - l0, done_cnt[0] - dn0, out595[0], prev_out);
        end
    endtask

    task automatic test_small_config();
        int a0, dn0, r0, i;
        a0 = acc_cnt[1]; dn0 = done_cnt[1]; r0 = rise_cnt[1];
        @(posedge clk); #2;
        data_in[1] = 16'h0081; valid_in[1] = 1'b1;
        i = 0;
        while (acc_cnt[1] == a0 && i < 50) begin @(negedge clk); #1; i++; end
        @(posedge clk); #2;
        valid_in[1] = 1'b0;
        i = 0;
        while (done_cnt[1] == dn0 && i < 200) begin @(negedge clk); #1; i++; end
        vectors++;
        if (out595[1] != 32'h81 || rise_cnt[1] - r0 != 8) begin
            miscompares++;
            $display("FAIL small_out: out %h rises %0d, required 81 and 8", out595[1],
                     rise_cnt[1] - r0);
        end
        vectors++;
        if (last_latch_t[1] - last_e0[1] != 16 || last_done_t[1] - last_e0[1] != 19 ||
            last_lat_w[1] != 3) begin
            miscompares++;
            $display("FAIL small_timing: latch +%0d done +%0d width %0d, required 16 19 3",
                     last_latch_t[1] - last_e0[1], last_done_t[1] - last_e0[1], last_lat_w[1]);
        end
    endtask

    task automatic rand_driver(input int d, input int n);
        int a0, i, m;
        m = (1 << w_p[d]) - 1;
        for (int k = 0; k < n; k++) begin
            a0 = acc_cnt[d];
            @(posedge clk); #2;
            data_in[d] = 16'($urandom & m);
            valid_in[d] = 1'b1;
            i = 0;
            while (acc_cnt[d] == a0 && i < 300) begin @(negedge clk); #1; i++; end
            if (acc_cnt[d] == a0) begin
                vectors++;
                miscompares++;
                $display("FAIL random_accept_timeout dut%0d: word %0d never accepted", d, k);
            end
            @(posedge clk); #2;
            if ($urandom_range(0, 1) == 1) begin
                valid_in[d] = 1'b0;
                data_in[d] = 16'($urandom);
                i = 0;
                while (done_cnt[d] < acc_cnt[d] && i < 300) begin @(negedge clk); #1; i++; end
                repeat ($urandom_range(0, 5)) @(posedge clk);
            end
        end
        @(posedge clk); #2;
        valid_in[d] = 1'b0;
    endtask

    task automatic test_random();
        int a0 [2];
        int l0 [2];
        int r0 [2];
        int i;
        for (int d = 0; d < 2; d++) begin
            a0[d] = acc_cnt[d]; l0[d] = latch_cnt[d]; r0[d] = rise_cnt[d];
        end
        fork
            rand_driver(0, 500);
            rand_driver(1, 500);
        join
        i = 0;
        while ((done_cnt[0] < acc_cnt[0] || done_cnt[1] < acc_cnt[1]) && i < 500) begin
            @(negedge clk); #1; i++;
        end
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (acc_cnt[d] - a0[d] != 500 || latch_cnt[d] - l0[d] != 500 ||
                rise_cnt[d] - r0[d] != 500 * w_p[d]) begin
                miscompares++;
                $display("FAIL random_totals dut%0d: accepts %0d latches %0d rises %0d, required 500 500 %0d",
                         d, acc_cnt[d] - a0[d], latch_cnt[d] - l0[d], rise_cnt[d] - r0[d],
                         500 * w_p[d]);
            end
        end
    endtask

    initial begin
        data_in[0] = 16'h0000;
        data_in[1] = 16'h0000;
        test_reset();
        test_pattern_a5c3();
        test_back_to_back();
        test_ignore_busy();
        test_reset_abort();
        test_small_config();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
